pipeline_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline front end. Decides each cycle whether
//  PC and the IF/ID latch advance, hold or flush, and whether ID/EX takes a bubble.

---
 rtl/pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard/sequencing controller for the 5-stage pipeline front end. Each cycle it decides
//   whether PC and IF/ID advance, hold or flush, and whether ID/EX takes a bubble. Sources are
//   load-use hazards, taken branches (multi-cycle squash) and instruction-memory wait.
//   Control outputs are combinational from registered state plus current inputs, so stalls
//   and flushes take effect in the same cycle the hazard is seen.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   id_rs, id_rt         source register fields of the instruction in ID
//   ex_rt, ex_mem_read   destination and load flag of the instruction in EX
//   branch_taken         branch resolved taken in EX this cycle
//   imem_ready           instruction memory returns a valid fetch this cycle
//   pc_write             PC loads its next value
//   ifid_write           IF/ID captures the fetched instruction
//   ifid_flush           IF/ID outputs forced to nop
//   idex_bubble          ID/EX control bits zeroed
//   state                FSM state for debug (RUN=0, FLUSH=1, IMEM_WAIT=2)
//   imem_err             sticky fetch-timeout flag, cleared only by reset
//   stall_cycles         saturating count of cycles with pc_write==0
module pipeline_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned WAIT_TIMEOUT = 64,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       ex_rt,
   input  logic             ex_mem_read,
   input  logic             branch_taken,
   input  logic             imem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       state,
   output logic             imem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned FCNT_W = 4;
   localparam int unsigned WCNT_W = 8;
   localparam bit          FLUSH_MULTI = (FLUSH_CYCLES > 1);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_FLUSH     = 2'd1,
      ST_IMEM_WAIT = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [FCNT_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;
   logic [WCNT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt, w_wait_inc;
   logic                r_imem_err, w_imem_err_nxt;
   logic [CNT_W-1:0]    r_stall_cycles;
   logic                w_load_use;
   logic                w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble;

   assign w_load_use = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   assign w_wait_inc = (r_wait_cnt == {WCNT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + WCNT_W'(1);

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_RUN;
         r_flush_cnt    <= '0;
         r_wait_cnt     <= '0;
         r_imem_err     <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_imem_err  <= w_imem_err_nxt;
         if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   // Next-state and pipeline control decode
   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_imem_err_nxt  = r_imem_err;
      w_pc_write      = 1'b1;
      w_ifid_write    = 1'b1;
      w_ifid_flush    = 1'b0;
      w_idex_bubble   = 1'b0;

      unique case (r_state)
         ST_RUN: begin
            if (branch_taken) begin
               w_ifid_flush  = 1'b1;
               w_idex_bubble = 1'b1;
               if (FLUSH_MULTI) begin
                  w_state_nxt     = ST_FLUSH;
                  w_flush_cnt_nxt = FCNT_W'(FLUSH_CYCLES - 1);
               end
            end else if (w_load_use) begin
               w_pc_write    = 1'b0;
               w_ifid_write  = 1'b0;
               w_idex_bubble = 1'b1;
            end else if (!imem_ready) begin
               w_pc_write     = 1'b0;
               w_ifid_write   = 1'b0;
               w_ifid_flush   = 1'b1;
               w_state_nxt    = ST_IMEM_WAIT;
               w_wait_cnt_nxt = WCNT_W'(1);
            end
         end

         // Squash window: branch/load-use belong to squashed instructions and are ignored
         ST_FLUSH: begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            if (!imem_ready) begin
               w_pc_write = 1'b0;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - FCNT_W'(1);
               if (r_flush_cnt <= FCNT_W'(1))
                  w_state_nxt = ST_RUN;
            end
         end

         ST_IMEM_WAIT: begin
            if (branch_taken) begin
               w_ifid_flush   = 1'b1;
               w_idex_bubble  = 1'b1;
               w_wait_cnt_nxt = '0;
               if (FLUSH_MULTI) begin
                  w_state_nxt     = ST_FLUSH;
                  w_flush_cnt_nxt = FCNT_W'(FLUSH_CYCLES - 1);
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end else begin
               w_pc_write    = 1'b0;
               w_ifid_write  = 1'b0;
               w_ifid_flush  = 1'b1;
               w_idex_bubble = w_load_use;
               if (imem_ready) begin
                  w_state_nxt    = ST_RUN;
                  w_wait_cnt_nxt = '0;
               end else begin
                  w_wait_cnt_nxt = w_wait_inc;
                  if (w_wait_inc == WCNT_W'(WAIT_TIMEOUT))
                     w_imem_err_nxt = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase

      // Hold the pipeline frozen and squashed while reset is asserted
      if (!rst_n) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
      end
   end

   assign pc_write     = w_pc_write;
   assign ifid_write   = w_ifid_write;
   assign ifid_flush   = w_ifid_flush;
   assign idex_bubble  = w_idex_bubble;
   assign state        = r_state;
   assign imem_err     = r_imem_err;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default instance plus a CNT_W=4 instance sharing
// the same stimulus, used for the counter saturation scenario.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        ex_mem_read, branch_taken, imem_ready;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, imem_err;
   logic [1:0]  state;
   logic [15:0] stall_cycles;
   logic        pc_write4, ifid_write4, ifid_flush4, idex_bubble4, imem_err4;
   logic [1:0]  state4;
   logic [3:0]  stall_cycles4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
      .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .imem_ready(imem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .state(state), .imem_err(imem_err),
      .stall_cycles(stall_cycles)
   );

   pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
      .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .imem_ready(imem_ready),
      .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
      .idex_bubble(idex_bubble4), .state(state4), .imem_err(imem_err4),
      .stall_cycles(stall_cycles4)
   );

   task automatic idle();
      id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
      ex_mem_read = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; idle();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle();
      #2;
      checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL rst_pc_write got=%0b exp=0", pc_write); end
      checks++; if (ifid_write !== 1'b0) begin failures++; $display("FAIL rst_ifid_write got=%0b exp=0", ifid_write); end
      checks++; if (ifid_flush !== 1'b1) begin failures++; $display("FAIL rst_ifid_flush got=%0b exp=1", ifid_flush); end
      checks++; if (idex_bubble !== 1'b1) begin failures++; $display("FAIL rst_idex_bubble got=%0b exp=1", idex_bubble); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
      checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (pc_write !== 1'b1 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0)
         begin failures++; $display("FAIL rst_release_run got=%0b%0b%0b exp=100", pc_write, ifid_flush, idex_bubble); end
      // enter FLUSH, then assert reset mid-cycle
      tick();
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0;
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL rst_pre_flush_state got=%0d exp=1", state); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_midflush_state got=%0d exp=0", state); end
      checks++; if (pc_write !== 1'b0 || ifid_flush !== 1'b1)
         begin failures++; $display("FAIL rst_midflush_out got=pc%0b fl%0b exp=pc0 fl1", pc_write, ifid_flush); end
      #1 rst_n = 1'b1;
      #1;
      checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0 || state !== 2'd0)
         begin failures++; $display("FAIL rst_release2 got=%0b%0b%0b%0b st%0d exp=1100 st0", pc_write, ifid_write, ifid_flush, idex_bubble, state); end
      tick();
   endtask

   task automatic test_load_use();
      idle();
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      #1;
      checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0 || ifid_flush !== 1'b0 || idex_bubble !== 1'b1)
         begin failures++; $display("FAIL lu_rs got=%0b%0b%0b%0b exp=0001", pc_write, ifid_write, ifid_flush, idex_bubble); end
      tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL lu_state got=%0d exp=0", state); end
      idle();
      #1;
      checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
         begin failures++; $display("FAIL lu_resume got=pc%0b bub%0b exp=pc1 bub0", pc_write, idex_bubble); end
      tick();
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7;
      #1;
      checks++; if (pc_write !== 1'b0 || idex_bubble !== 1'b1)
         begin failures++; $display("FAIL lu_rt got=pc%0b bub%0b exp=pc0 bub1", pc_write, idex_bubble); end
      tick();
      ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      #1;
      checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
         begin failures++; $display("FAIL lu_r0 got=pc%0b bub%0b exp=pc1 bub0", pc_write, idex_bubble); end
      tick();
      ex_mem_read = 1'b0; ex_rt = 5'd9; id_rs = 5'd9;
      #1;
      checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
         begin failures++; $display("FAIL lu_noload got=pc%0b bub%0b exp=pc1 bub0", pc_write, idex_bubble); end
      tick();
      idle();
   endtask

   task automatic test_branch();
      idle();
      branch_taken = 1'b1;
      #1;
      checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1)
         begin failures++; $display("FAIL br_detect got=%0b%0b%0b%0b exp=1111", pc_write, ifid_write, ifid_flush, idex_bubble); end
      tick();
      // second flush cycle: a new branch and a load-use are both squashed
      ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
      #1;
      checks++; if (state !== 2'd1 || ifid_flush !== 1'b1 || pc_write !== 1'b1)
         begin failures++; $display("FAIL br_flush2 got=st%0d fl%0b pc%0b exp=st1 fl1 pc1", state, ifid_flush, pc_write); end
      tick();
      idle();
      #1;
      checks++; if (state !== 2'd0 || ifid_flush !== 1'b0 || pc_write !== 1'b1)
         begin failures++; $display("FAIL br_back_run got=st%0d fl%0b pc%0b exp=st0 fl0 pc1", state, ifid_flush, pc_write); end
      // flush held by fetch wait
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0; imem_ready = 1'b0;
      #1;
      checks++; if (state !== 2'd1 || pc_write !== 1'b0 || ifid_flush !== 1'b1)
         begin failures++; $display("FAIL br_wait got=st%0d pc%0b fl%0b exp=st1 pc0 fl1", state, pc_write, ifid_flush); end
      tick();
      imem_ready = 1'b1;
      #1;
      checks++; if (state !== 2'd1 || pc_write !== 1'b1)
         begin failures++; $display("FAIL br_wait_hold got=st%0d pc%0b exp=st1 pc1", state, pc_write); end
      tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL br_wait_exit got=%0d exp=0", state); end
   endtask

   task automatic test_branch_load_use();
      idle();
      branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd6; id_rt = 5'd6;
      #1;
      checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1)
         begin failures++; $display("FAIL brlu got=%0b%0b%0b%0b exp=1111", pc_write, ifid_write, ifid_flush, idex_bubble); end
      tick();
      idle();
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL brlu_state got=%0d exp=1", state); end
      tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL brlu_exit got=%0d exp=0", state); end
   endtask

   task automatic test_imem_timeout();
      do_reset();
      imem_ready = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         if (k == 10) begin ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; end
         if (k == 11) begin ex_mem_read = 1'b0; ex_rt = 5'd3; id_rs = 5'd1; end
         #1;
         checks++; if (pc_write !== 1'b0 || ifid_flush !== 1'b1)
            begin failures++; $display("FAIL to_wait_out k=%0d got=pc%0b fl%0b exp=pc0 fl1", k, pc_write, ifid_flush); end
         checks++; if (state !== ((k == 1) ? 2'd0 : 2'd2))
            begin failures++; $display("FAIL to_state k=%0d got=%0d exp=%0d", k, state, (k == 1) ? 0 : 2); end
         // flag registers at the end of the 64th waiting cycle
         checks++; if (imem_err !== (k >= 65))
            begin failures++; $display("FAIL to_err k=%0d got=%0b exp=%0b", k, imem_err, (k >= 65)); end
         if (k == 10) begin
            checks++; if (idex_bubble !== 1'b1)
               begin failures++; $display("FAIL to_lu_bubble got=%0b exp=1", idex_bubble); end
         end
         tick();
      end
      imem_ready = 1'b1;
      #1;
      checks++; if (state !== 2'd2 || pc_write !== 1'b0 || imem_err !== 1'b1)
         begin failures++; $display("FAIL to_handoff got=st%0d pc%0b err%0b exp=st2 pc0 err1", state, pc_write, imem_err); end
      tick();
      #1;
      checks++; if (state !== 2'd0 || pc_write !== 1'b1 || imem_err !== 1'b1)
         begin failures++; $display("FAIL to_resume got=st%0d pc%0b err%0b exp=st0 pc1 err1", state, pc_write, imem_err); end
      // 70 low-ready cycles plus the IMEM_WAIT cycle in which ready returns
      checks++; if (stall_cycles !== 16'd71)
         begin failures++; $display("FAIL to_stall got=%0d exp=71", stall_cycles); end
   endtask

   task automatic test_imem_branch();
      idle();
      imem_ready = 1'b0;
      tick();
      tick();
      branch_taken = 1'b1;
      #1;
      checks++; if (state !== 2'd2 || pc_write !== 1'b1 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1)
         begin failures++; $display("FAIL wb_out got=st%0d pc%0b fl%0b bub%0b exp=st2 pc1 fl1 bub1", state, pc_write, ifid_flush, idex_bubble); end
      tick();
      idle();
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL wb_flush got=%0d exp=1", state); end
      tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL wb_run got=%0d exp=0", state); end
   endtask

   task automatic test_saturation();
      rst_n = 1'b0; idle();
      ex_mem_read = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
      #3 rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14 || i == 15 || i == 20) begin
            checks++; if (stall_cycles4 !== 4'((i > 15) ? 15 : i))
               begin failures++; $display("FAIL sat4 i=%0d got=%0d exp=%0d", i, stall_cycles4, (i > 15) ? 15 : i); end
         end
      end
      checks++; if (stall_cycles !== 16'd20)
         begin failures++; $display("FAIL sat16 got=%0d exp=20", stall_cycles); end
      idle();
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      test_reset();
      test_load_use();
      test_branch();
      test_branch_load_use();
      test_imem_timeout();
      test_imem_branch();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
